if_prefetch: RTL

Parametrised instruction-fetch stage with a prefetch queue for the pipelined 16-bit core. Issues sequential reads to the synchronous instruction ROM and buffers returned words with their PC in a small FIFO. Delivers them to decode over a valid/ready handshake. It stops fetching past control-flow instructions, halts on an all-zero word or at the end of ROM, and redirects on jumps and interrupts.

---
 rtl/if_pkg.sv | 20 ++
 rtl/if_fifo.sv | 57 +++++
 rtl/if_prefetch.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch stage: opcodes that redirect
// control flow, the fetch FSM state encoding and the control-flow classifier.
package if_pkg;

  localparam logic [4:0] BEQ = 5'h10;
  localparam logic [4:0] BLE = 5'h11;
  localparam logic [4:0] JAL = 5'h12;
  localparam logic [4:0] JR  = 5'h13;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    WAIT_BR = 2'd1,
    HALT    = 2'd2
  } fetch_state_t;

  function automatic logic is_ctrl_flow(input logic [4:0] opcode);
    return (opcode == BEQ) || (opcode == BLE) || (opcode == JAL) || (opcode == JR);
  endfunction

endpackage

// File: rtl/if_fifo.sv
// Show-ahead prefetch FIFO: the head entry is visible whenever o_valid is high.
// Flush empties the queue and wins over any push or pop in the same cycle.
module if_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic                     o_valid,
  output logic [WIDTH-1:0]         o_rdata,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign w_pop  = i_pop && (r_count != '0) && !i_flush;
  assign w_push = i_push && !i_flush && (w_pop || (r_count != CW'(DEPTH)));

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

  assign o_valid = (r_count != '0);
  assign o_rdata = o_valid ? r_mem[r_rd_ptr] : '0;
  assign o_count = r_count;

endmodule

// File: rtl/if_prefetch.sv
// Instruction-fetch stage: sequential ROM reads into a prefetch FIFO, stalling
// behind control flow, halting on a zero word or end of ROM, redirecting on jumps/IRQs.
module if_prefetch
  import if_pkg::*;
#(
  parameter int                ADDR_W     = 16,
  parameter int                DATA_W     = 16,
  parameter int                ROM_DEPTH  = 256,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter logic [ADDR_W-1:0] INT_VEC    = 16'h0004
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              jump_flag,
  input  logic [ADDR_W-1:0] jump_pc,
  input  logic              br_resolve,
  input  logic              int_req,
  output logic              int_ack,
  output logic [ADDR_W-1:0] epc,
  output logic [ADDR_W-1:0] inst_addr,
  output logic              inst_rd_en,
  input  logic [DATA_W-1:0] inst_data,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [DATA_W-1:0] id_inst,
  output logic [ADDR_W-1:0] id_pc,
  output logic              halted,
  output fetch_state_t      dbg_state
);

  localparam int                CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(ROM_DEPTH - 1);

  fetch_state_t        r_state;
  logic [ADDR_W-1:0]   r_pc;
  logic [ADDR_W-1:0]   r_iss_pc;
  logic [ADDR_W-1:0]   r_epc;
  logic                r_inflight;
  logic                r_end;
  logic                r_int_ack;

  logic                w_take_int;
  logic                w_redirect;
  logic                w_resp;
  logic                w_resp_zero;
  logic                w_resp_ctrl;
  logic                w_room;
  logic                w_issue;
  logic [CW-1:0]       w_count;
  logic [ADDR_W-1:0]   w_next_pc;
  logic [DATA_W+ADDR_W-1:0] w_head;

  assign w_take_int  = int_req && !jump_flag && (r_state != WAIT_BR);
  assign w_redirect  = jump_flag || w_take_int;
  assign w_resp      = r_inflight && !w_redirect;
  assign w_resp_zero = w_resp && (inst_data == '0);
  assign w_resp_ctrl = w_resp && !w_resp_zero && is_ctrl_flow(inst_data[4:0]);
  assign w_room      = (32'(w_count) + 32'(r_inflight)) < 32'(FIFO_DEPTH);

  // A response that halts or branches blocks the issue in its own cycle, so
  // nothing past it is ever fetched.
  assign w_issue = !rst && (r_state == RUN) && !hold && !w_redirect && !r_end &&
                   w_room && !w_resp_zero && !w_resp_ctrl;

  assign inst_rd_en = w_issue;
  assign inst_addr  = r_pc;
  assign w_next_pc  = r_inflight ? r_iss_pc : r_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= RUN;
      r_pc       <= RESET_PC;
      r_iss_pc   <= '0;
      r_inflight <= 1'b0;
      r_end      <= 1'b0;
      r_int_ack  <= 1'b0;
      r_epc      <= '0;
    end else begin
      r_int_ack <= 1'b0;
      if (jump_flag) begin
        r_pc       <= jump_pc;
        r_state    <= RUN;
        r_inflight <= 1'b0;
        r_end      <= 1'b0;
      end else if (w_take_int) begin
        r_pc       <= INT_VEC;
        r_state    <= RUN;
        r_inflight <= 1'b0;
        r_end      <= 1'b0;
        r_int_ack  <= 1'b1;
        r_epc      <= id_valid ? id_pc : w_next_pc;
      end else begin
        r_inflight <= w_issue;
        if (w_issue) begin
          r_iss_pc <= r_pc;
          if (r_pc == LAST_PC) r_end <= 1'b1;
          else                 r_pc  <= r_pc + 1'b1;
        end
        // A halted pc points at the zero word so it is the interrupt return address.
        if (w_resp_zero) begin
          r_state <= HALT;
          r_pc    <= r_iss_pc;
        end else if (w_resp && r_end) begin
          r_state <= HALT;
        end else if (w_resp_ctrl) begin
          r_state <= WAIT_BR;
        end else if ((r_state == WAIT_BR) && br_resolve) begin
          r_state <= RUN;
        end
      end
    end
  end

  // Decode handshake: an entry moves on a rising edge where id_valid && id_ready;
  // id_valid never depends on id_ready and the head holds steady until taken.
  if_fifo #(
    .WIDTH (DATA_W + ADDR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (w_redirect),
    .i_push  (w_resp && !w_resp_zero),
    .i_wdata ({inst_data, r_iss_pc}),
    .i_pop   (id_ready),
    .o_valid (id_valid),
    .o_rdata (w_head),
    .o_count (w_count)
  );

  assign id_inst   = w_head[ADDR_W +: DATA_W];
  assign id_pc     = w_head[ADDR_W-1:0];
  assign int_ack   = r_int_ack;
  assign epc       = r_epc;
  assign halted    = (r_state == HALT);
  assign dbg_state = r_state;

endmodule
